// File: rtl/modmul_engine_if.sv
// Purpose : Handshake/bus bundle for the modular multiplier engine.
// Signals : in_valid/in_ready + X, Y, M, sq   operand side (scheduler -> engine)
//           out_valid/out_ready + Q, err      result side (engine -> sink)
//           flush                             synchronous abort
//           busy                              engine not idle
// Modports: master = scheduler/sink side, slave = engine side.
interface modmul_engine_if #(
  parameter int unsigned WIDTH = 256
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] M;
  logic             sq;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, X, Y, M, sq, flush, out_ready,
    input  in_ready, out_valid, Q, err, busy
  );

  modport slave (
    input  in_valid, X, Y, M, sq, flush, out_ready,
    output in_ready, out_valid, Q, err, busy
  );

endinterface

// File: rtl/modmul_engine.sv
// Purpose : Runtime-modulus modular multiplier, Q = X*Y mod M (or X*X mod M),
//           using bit-serial interleaved (Blakley) reduction, MSB first.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    modmul_engine_if.slave (operand/result handshakes, flush, busy)
// Latency : accept at t0, CHECK at t0+1, WIDTH CALC edges, result valid at
//           t0+WIDTH+1 (t0+1 for illegal operands).
module modmul_engine #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  modmul_engine_if.slave    bus
);

  // Intermediate sum 2P + Y is below 3M, so two extra bits suffice.
  localparam int unsigned TW = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_CALC  = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e           state_q, state_d;

  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic             accept_c;
  logic             illegal_c;
  logic [TW-1:0]    m_ext_c;
  logic [TW-1:0]    t_add_c;
  logic [TW-1:0]    t_sub1_c;
  logic [WIDTH-1:0] t_res_c;

  // Flush beats a simultaneous accept, so nothing is captured then.
  assign accept_c  = bus.in_valid && in_ready_q && (state_q == S_IDLE) && !bus.flush;

  // In square mode yr_q holds X, so the Y range test degenerates to the X test.
  assign illegal_c = (m_q < WIDTH'(2)) || (xr_q >= m_q) || (yr_q >= m_q);

  // One Blakley step: T = 2P + x_bit*Y, then up to two conditional subtractions.
  assign m_ext_c  = {2'b00, m_q};
  assign t_add_c  = {1'b0, p_q, 1'b0} + (xr_q[cnt_q] ? {2'b00, yr_q} : TW'(0));
  assign t_sub1_c = (t_add_c >= m_ext_c) ? (t_add_c - m_ext_c) : t_add_c;
  // After the second subtraction T < M, so the top two bits are always zero.
  assign t_res_c  = WIDTH'((t_sub1_c >= m_ext_c) ? (t_sub1_c - m_ext_c) : t_sub1_c);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept_c) state_d = S_CHECK;
        S_CHECK: state_d = illegal_c ? S_OUT : S_CALC;
        S_CALC:  if (cnt_q == '0) state_d = S_OUT;
        S_OUT:   if (bus.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    xr_d        = xr_q;
    yr_d        = yr_q;
    m_d         = m_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);

    if (bus.flush) begin
      // Abort: Q/err deliberately keep their last delivered values.
      out_valid_d = 1'b0;
      p_d         = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            xr_d = bus.X;
            yr_d = bus.sq ? bus.X : bus.Y;
            m_d  = bus.M;
          end
        end
        S_CHECK: begin
          if (illegal_c) begin
            q_d         = '0;
            err_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            p_d   = '0;
            cnt_d = CNT_W'(WIDTH - 1);
          end
        end
        S_CALC: begin
          p_d = t_res_c;
          if (cnt_q == '0) begin
            q_d         = t_res_c;
            err_d       = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) out_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr_q        <= '0;
      yr_q        <= '0;
      m_q         <= '0;
      p_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      xr_q        <= xr_d;
      yr_q        <= yr_d;
      m_q         <= m_d;
      p_q         <= p_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Q         = q_q;
  assign bus.err       = err_q;
  assign bus.busy      = busy_q;

  // Partial product stays reduced throughout the multiply.
  a_p_lt_m: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_CALC) |-> (p_q < m_q));

  // A result is only ever presented from the OUT state.
  a_ov_in_out: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q |-> (state_q == S_OUT));

endmodule

// File: tb/tb_modmul_engine.sv
// Purpose : Self-checking bench for modmul_engine. Two instances (WIDTH=8 and
//           WIDTH=256) share clock and reset; results are checked against a
//           wide-arithmetic reference (X*Y) % M.
module tb_modmul_engine;

  logic clk;
  logic rst_n;

  modmul_engine_if #(.WIDTH(8))   bus8   ();
  modmul_engine_if #(.WIDTH(256)) bus256 ();

  modmul_engine #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  modmul_engine #(.WIDTH(256)) dut256 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus256.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide multiply and modulo.
  task automatic ref_model(input logic [255:0] x, input logic [255:0] y,
                           input logic [255:0] m, input bit sq,
                           output logic [255:0] q, output logic err);
    logic [511:0] prod;
    logic [255:0] yy;
    yy = sq ? x : y;
    if (m < 256'd2 || x >= m || yy >= m) begin
      q   = '0;
      err = 1'b1;
    end else begin
      prod = {256'd0, x} * {256'd0, yy};
      prod = prod % {256'd0, m};
      q    = prod[255:0];
      err  = 1'b0;
    end
  endtask

  function automatic logic [255:0] f_q(bit w8);
    return w8 ? 256'(bus8.Q) : bus256.Q;
  endfunction
  function automatic logic f_ov(bit w8);
    return w8 ? bus8.out_valid : bus256.out_valid;
  endfunction
  function automatic logic f_err(bit w8);
    return w8 ? bus8.err : bus256.err;
  endfunction
  function automatic logic f_rdy(bit w8);
    return w8 ? bus8.in_ready : bus256.in_ready;
  endfunction
  function automatic logic f_busy(bit w8);
    return w8 ? bus8.busy : bus256.busy;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_in(input bit w8, input logic v, input logic [255:0] x,
                        input logic [255:0] y, input logic [255:0] m, input bit sq);
    if (w8) begin
      bus8.in_valid = v;
      bus8.X = x[7:0];
      bus8.Y = y[7:0];
      bus8.M = m[7:0];
      bus8.sq = sq;
    end else begin
      bus256.in_valid = v;
      bus256.X = x;
      bus256.Y = y;
      bus256.M = m;
      bus256.sq = sq;
    end
  endtask

  // Called at a negedge: waits for in_ready, presents operands for one edge.
  task automatic op_start(input bit w8, input logic [255:0] x, input logic [255:0] y,
                          input logic [255:0] m, input bit sq, input string tag);
    int n;
    n = 0;
    while (!f_rdy(w8) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".in_ready"}, 256'(f_rdy(w8)), 256'd1);
    set_in(w8, 1'b1, x, y, m, sq);
    @(negedge clk);
    set_in(w8, 1'b0, x, y, m, sq);
    chk({tag, ".busy"}, 256'(f_busy(w8)), 256'd1);
  endtask

  // Called at the negedge right after the accept edge: checks latency and result.
  task automatic op_wait(input bit w8, input logic [255:0] x, input logic [255:0] y,
                         input logic [255:0] m, input bit sq, input string tag);
    logic [255:0] exp_q;
    logic         exp_err;
    int           lat;
    int           w;
    w = w8 ? 8 : 256;
    ref_model(x, y, m, sq, exp_q, exp_err);
    lat = 0;
    while (!f_ov(w8) && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 256'(lat), exp_err ? 256'd1 : 256'(w + 1));
    chk({tag, ".q"}, f_q(w8), exp_q);
    chk({tag, ".err"}, 256'(f_err(w8)), 256'(exp_err));
  endtask

  // With out_ready high, the result is consumed on the next edge.
  task automatic op_done(input bit w8, input string tag);
    @(negedge clk);
    chk({tag, ".ov_clr"}, 256'(f_ov(w8)), 256'd0);
    chk({tag, ".idle"}, 256'(f_rdy(w8)), 256'd1);
  endtask

  task automatic do_op(input bit w8, input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] m, input bit sq, input string tag);
    op_start(w8, x, y, m, sq, tag);
    op_wait(w8, x, y, m, sq, tag);
    op_done(w8, tag);
  endtask

  localparam logic [255:0] M256 =
    256'h92e5c273477d21d8361651a6eea3cb5b1c424d77f1b750a99cc6df2b0ee713a2;
  localparam logic [255:0] Q2_256 =
    256'h6d1a3d8cb882de27c9e9ae59115c34a4e3bdb2880e48af56633920d4f118ec5e;

  initial begin
    logic [255:0] x, y, m, q_prev;
    logic [255:0] p255;
    bit           sq, seen_ov;

    rst_n = 1'b0;
    set_in(1'b1, 1'b0, '0, '0, '0, 1'b0);
    set_in(1'b0, 1'b0, '0, '0, '0, 1'b0);
    bus8.flush = 1'b0;    bus8.out_ready = 1'b1;
    bus256.flush = 1'b0;  bus256.out_ready = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      chk("rst.q",         f_q(b == 0),           256'd0);
      chk("rst.err",       256'(f_err(b == 0)),  256'd0);
      chk("rst.out_valid", 256'(f_ov(b == 0)),   256'd0);
      chk("rst.busy",      256'(f_busy(b == 0)), 256'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready8",   256'(f_rdy(1'b1)), 256'd1);
    chk("rst.in_ready256", 256'(f_rdy(1'b0)), 256'd1);

    // Flush coincident with accept: nothing captured.
    set_in(1'b1, 1'b1, 256'd7, 256'd9, 256'd13, 1'b0);
    bus8.flush = 1'b1;
    @(negedge clk);
    bus8.flush = 1'b0;
    set_in(1'b1, 1'b0, 256'd7, 256'd9, 256'd13, 1'b0);
    chk("flush_acc.busy",  256'(f_busy(1'b1)), 256'd0);
    chk("flush_acc.ready", 256'(f_rdy(1'b1)),  256'd1);
    @(negedge clk);
    chk("flush_acc.ov",    256'(f_ov(1'b1)),   256'd0);

    // Directed WIDTH=8 cases.
    do_op(1'b1, 256'd7,  256'd9,    256'd13, 1'b0, "d8_7x9");
    chk("d8_7x9.q_const", f_q(1'b1), 256'd11);
    do_op(1'b1, 256'd12, 256'hFF,   256'd13, 1'b1, "d8_sq12");
    chk("d8_sq12.q_const", f_q(1'b1), 256'd1);
    do_op(1'b1, 256'd13, 256'd1,    256'd13, 1'b0, "d8_x_eq_m");
    do_op(1'b1, 256'd0,  256'd0,    256'd1,  1'b0, "d8_m1");
    do_op(1'b1, 256'd3,  256'd13,   256'd13, 1'b0, "d8_y_eq_m");
    do_op(1'b1, 256'd254, 256'd254, 256'd255, 1'b0, "d8_max");

    // Directed WIDTH=256 cases.
    do_op(1'b0, M256 - 256'd1, M256 - 256'd1, M256, 1'b0, "d256_mm1sq");
    chk("d256_mm1sq.q_const", f_q(1'b0), 256'd1);
    p255 = '0;
    p255[255] = 1'b1;
    do_op(1'b0, p255, 256'd2, M256, 1'b0, "d256_pow256");
    chk("d256_pow256.q_const", f_q(1'b0), Q2_256);

    // Randomized WIDTH=8 operations, including some illegal operand sets.
    for (int i = 0; i < 24; i++) begin
      m  = 256'($urandom_range(0, 255));
      x  = (i % 4 == 0 || m == 0) ? 256'($urandom_range(0, 255)) : 256'($urandom) % m;
      y  = (i % 5 == 0 || m == 0) ? 256'($urandom_range(0, 255)) : 256'($urandom) % m;
      sq = 1'($urandom_range(0, 1));
      do_op(1'b1, x, y, m, sq, "rnd8");
    end

    // Randomized WIDTH=256 operations.
    for (int i = 0; i < 5; i++) begin
      m = rand256();
      if (m < 256'd2) m = 256'd2;
      x = (i == 4) ? m : rand256() % m;
      y = rand256() % m;
      sq = (i == 2);
      do_op(1'b0, x, y, m, sq, "rnd256");
    end

    // Backpressure: result held, new operands refused until consumed.
    bus8.out_ready = 1'b0;
    op_start(1'b1, 256'd3, 256'd4, 256'd13, 1'b0, "bp");
    op_wait(1'b1, 256'd3, 256'd4, 256'd13, 1'b0, "bp");
    set_in(1'b1, 1'b1, 256'd6, 256'd7, 256'd13, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp.hold_ov",  256'(f_ov(1'b1)),   256'd1);
      chk("bp.hold_q",   f_q(1'b1),           256'd12);
      chk("bp.hold_rdy", 256'(f_rdy(1'b1)),  256'd0);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.release_ov",  256'(f_ov(1'b1)),  256'd0);
    chk("bp.release_rdy", 256'(f_rdy(1'b1)), 256'd1);
    @(negedge clk);
    set_in(1'b1, 1'b0, 256'd6, 256'd7, 256'd13, 1'b0);
    chk("bp.next_busy", 256'(f_busy(1'b1)), 256'd1);
    op_wait(1'b1, 256'd6, 256'd7, 256'd13, 1'b0, "bp_next");
    op_done(1'b1, "bp_next");

    // Flush during CALC: back to idle, result never presented, Q retained.
    q_prev = f_q(1'b1);
    op_start(1'b1, 256'd9, 256'd10, 256'd13, 1'b0, "flush");
    repeat (3) @(negedge clk);
    bus8.flush = 1'b1;
    @(negedge clk);
    bus8.flush = 1'b0;
    chk("flush.busy",  256'(f_busy(1'b1)), 256'd0);
    chk("flush.ready", 256'(f_rdy(1'b1)),  256'd1);
    chk("flush.q",     f_q(1'b1),          q_prev);
    seen_ov = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (f_ov(1'b1)) seen_ov = 1'b1;
    end
    chk("flush.never_ov", 256'(seen_ov), 256'd0);

    // Asynchronous reset mid-CALC.
    op_start(1'b1, 256'd11, 256'd12, 256'd13, 1'b0, "arst");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.q",     f_q(1'b1),           256'd0);
    chk("arst.err",   256'(f_err(1'b1)),  256'd0);
    chk("arst.ov",    256'(f_ov(1'b1)),   256'd0);
    chk("arst.busy",  256'(f_busy(1'b1)), 256'd0);
    chk("arst.ready", 256'(f_rdy(1'b1)),  256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b1, 256'd5, 256'd5, 256'd13, 1'b0, "after_rst");
    chk("after_rst.q_const", f_q(1'b1), 256'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
